// File: rtl/operand_collector_if.sv
// operand_collector_if: bundles the three handshake channels of the operand collector.
//   insn_*    : instruction in from issue (valid/ready, tag, operand mask, packed addresses)
//   rf_read_* : read request out to the register-file bank (valid/ready, address)
//   rf_resp_* : bank response in (valid, echoed address, data), single-cycle latency
//   opc_*     : operand bundle out to execution (valid/ready, tag, packed data)
// Signal suffixes are from the collector's point of view. The collector uses the
// slave modport; the issue stage, bank and execution side together use master.
interface operand_collector_if #(
    parameter int unsigned NumOperands = 3,
    parameter int unsigned AddrWidth   = 8,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned TagWidth    = 4
);
    logic                             insn_valid_i;
    logic                             insn_ready_o;
    logic [TagWidth-1:0]              insn_tag_i;
    logic [NumOperands-1:0]           insn_op_valid_i;
    logic [NumOperands*AddrWidth-1:0] insn_op_addr_i;

    logic                             rf_read_valid_o;
    logic                             rf_read_ready_i;
    logic [AddrWidth-1:0]             rf_read_addr_o;

    logic                             rf_resp_valid_i;
    logic [AddrWidth-1:0]             rf_resp_addr_i;
    logic [DataWidth-1:0]             rf_resp_data_i;

    logic                             opc_valid_o;
    logic                             opc_ready_i;
    logic [TagWidth-1:0]              opc_tag_o;
    logic [NumOperands*DataWidth-1:0] opc_data_o;

    modport slave (
        input  insn_valid_i, insn_tag_i, insn_op_valid_i, insn_op_addr_i,
        input  rf_read_ready_i, rf_resp_valid_i, rf_resp_addr_i, rf_resp_data_i,
        input  opc_ready_i,
        output insn_ready_o, rf_read_valid_o, rf_read_addr_o,
        output opc_valid_o, opc_tag_o, opc_data_o
    );

    modport master (
        output insn_valid_i, insn_tag_i, insn_op_valid_i, insn_op_addr_i,
        output rf_read_ready_i, rf_resp_valid_i, rf_resp_addr_i, rf_resp_data_i,
        output opc_ready_i,
        input  insn_ready_o, rf_read_valid_o, rf_read_addr_o,
        input  opc_valid_o, opc_tag_o, opc_data_o
    );
endinterface

// File: rtl/operand_collector.sv
// operand_collector: accepts one instruction with up to NumOperands source registers,
// issues one bank read per valid operand (ascending index order, back-to-back), captures
// the single-cycle-latency responses into slots and hands the bundle downstream.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : operand_collector_if.slave (insn in, rf read/resp, opc bundle out)
module operand_collector #(
    parameter int unsigned NumOperands  = 3,
    parameter int unsigned NumRegisters = 256,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned TagWidth     = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    operand_collector_if.slave bus
);
    localparam int unsigned AddrWidth = $clog2(NumRegisters);
    localparam int unsigned IdxWidth  = (NumOperands > 1) ? $clog2(NumOperands) : 1;

    typedef enum logic [1:0] {StIdle, StRequest, StWait, StDispatch} state_e;

    state_e                 state_q, state_d;
    logic [TagWidth-1:0]    tag_q, tag_d;
    logic [NumOperands-1:0] rem_q, rem_d;   // operands still to be requested
    logic [AddrWidth-1:0]   addr_q [NumOperands];
    logic [AddrWidth-1:0]   addr_d [NumOperands];
    logic [DataWidth-1:0]   data_q [NumOperands];
    logic [DataWidth-1:0]   data_d [NumOperands];
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic [IdxWidth-1:0]    resp_idx_q, resp_idx_d;
    logic                   resp_pending_q, resp_pending_d;

    logic                   req_hs;
    logic [NumOperands-1:0] rem_next;

    function automatic logic [IdxWidth-1:0] lowest_set(input logic [NumOperands-1:0] m);
        lowest_set = '0;
        for (int i = NumOperands - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IdxWidth'(i);
        end
    endfunction

    always_comb begin
        state_d          = state_q;
        tag_d            = tag_q;
        rem_d            = rem_q;
        addr_d           = addr_q;
        data_d           = data_q;
        idx_d            = idx_q;
        resp_idx_d       = resp_idx_q;
        rem_next         = rem_q;
        req_hs           = 1'b0;
        bus.insn_ready_o    = 1'b0;
        bus.rf_read_valid_o = 1'b0;
        bus.rf_read_addr_o  = '0;
        bus.opc_valid_o     = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.insn_ready_o = 1'b1;
                if (bus.insn_valid_i) begin
                    tag_d = bus.insn_tag_i;
                    rem_d = bus.insn_op_valid_i;
                    for (int i = 0; i < NumOperands; i++) begin
                        addr_d[i] = bus.insn_op_addr_i[i*AddrWidth +: AddrWidth];
                        data_d[i] = '0;
                    end
                    idx_d   = lowest_set(bus.insn_op_valid_i);
                    state_d = (bus.insn_op_valid_i == '0) ? StDispatch : StRequest;
                end
            end
            StRequest: begin
                bus.rf_read_valid_o = 1'b1;
                bus.rf_read_addr_o  = addr_q[idx_q];
                if (bus.rf_read_ready_i) begin
                    req_hs          = 1'b1;
                    rem_next[idx_q] = 1'b0;
                    rem_d           = rem_next;
                    idx_d           = lowest_set(rem_next);
                    if (rem_next == '0) state_d = StWait;
                end
            end
            StWait: begin
                // Only the last response can still be outstanding here.
                if (resp_pending_q && bus.rf_resp_valid_i) state_d = StDispatch;
            end
            StDispatch: begin
                bus.opc_valid_o = 1'b1;
                if (bus.opc_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Capture runs in every state so the last REQUEST response lands while in WAIT.
        if (resp_pending_q && bus.rf_resp_valid_i) data_d[resp_idx_q] = bus.rf_resp_data_i;
        resp_pending_d = req_hs;
        if (req_hs) resp_idx_d = idx_q;
    end

    always_comb begin
        bus.opc_tag_o  = tag_q;
        bus.opc_data_o = '0;
        for (int i = 0; i < NumOperands; i++) begin
            bus.opc_data_o[i*DataWidth +: DataWidth] = data_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            tag_q          <= '0;
            rem_q          <= '0;
            idx_q          <= '0;
            resp_idx_q     <= '0;
            resp_pending_q <= 1'b0;
            for (int i = 0; i < NumOperands; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            rem_q          <= rem_d;
            idx_q          <= idx_d;
            resp_idx_q     <= resp_idx_d;
            resp_pending_q <= resp_pending_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
        end
    end

    resp_follows_req_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.rf_read_valid_o && bus.rf_read_ready_i) |=>
        (bus.rf_resp_valid_i && bus.rf_resp_addr_i == $past(bus.rf_read_addr_o)));

    resp_expected_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.rf_resp_valid_i |-> resp_pending_q);
endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;
    localparam int unsigned NumOperands = 3;
    localparam int unsigned AddrWidth   = 8;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned TagWidth    = 4;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    operand_collector_if #(
        .NumOperands(NumOperands), .AddrWidth(AddrWidth),
        .DataWidth(DataWidth), .TagWidth(TagWidth)
    ) bus ();

    operand_collector #(
        .NumOperands(NumOperands), .NumRegisters(256),
        .DataWidth(DataWidth), .TagWidth(TagWidth)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    typedef struct {
        logic [TagWidth-1:0]              tag;
        logic [NumOperands*DataWidth-1:0] data;
        int                               lat;
    } exp_t;

    exp_t                 exp_q [$];
    logic [AddrWidth-1:0] rdq [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int insn_cyc = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    bit opc_valid_prev = 1'b0;
    bit opc_hs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: mem[r] = r * 0x11, response exactly one cycle after the handshake.
    always @(posedge clk) begin
        bus.rf_resp_valid_i <= bus.rf_read_valid_o && bus.rf_read_ready_i;
        bus.rf_resp_addr_i  <= bus.rf_read_addr_o;
        bus.rf_resp_data_i  <= 32'(bus.rf_read_addr_o) * 32'h11;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (!rst_ni) return;
        if (bus.insn_valid_i && bus.insn_ready_o) insn_cyc = cyc;
        if (bus.rf_read_valid_o) begin
            check_eq("rd_expected", 128'(rdq.size() != 0), 128'(1));
            if (rdq.size() != 0) begin
                check_eq("rd_addr", 128'(bus.rf_read_addr_o), 128'(rdq[0]));
                if (bus.rf_read_ready_i) begin
                    void'(rdq.pop_front());
                    req_cnt++;
                end
            end
        end
        if (opc_hs_prev) begin
            check_eq("idle_after_hs", 128'(bus.insn_ready_o), 128'(1));
            check_eq("valid_dropped", 128'(bus.opc_valid_o), 128'(0));
        end
        opc_hs_prev = 1'b0;
        if (bus.opc_valid_o) begin
            check_eq("busy_not_ready", 128'(bus.insn_ready_o), 128'(0));
            check_eq("opc_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                if (!opc_valid_prev) check_eq("latency", 128'(cyc - insn_cyc), 128'(exp_q[0].lat));
                check_eq("opc_tag", 128'(bus.opc_tag_o), 128'(exp_q[0].tag));
                check_eq("opc_data", 128'(bus.opc_data_o), 128'(exp_q[0].data));
                if (bus.opc_ready_i) begin
                    void'(exp_q.pop_front());
                    done_cnt++;
                    opc_hs_prev = 1'b1;
                end
            end
        end
        opc_valid_prev = bus.opc_valid_o;
    endtask

    // Sample mid-cycle, then return 1 time unit after the next rising edge.
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_insn_ready"}, 128'(bus.insn_ready_o), 128'(1));
        check_eq({pfx, "_rd_valid"}, 128'(bus.rf_read_valid_o), 128'(0));
        check_eq({pfx, "_rd_addr"}, 128'(bus.rf_read_addr_o), 128'(0));
        check_eq({pfx, "_opc_valid"}, 128'(bus.opc_valid_o), 128'(0));
        check_eq({pfx, "_opc_tag"}, 128'(bus.opc_tag_o), 128'(0));
        check_eq({pfx, "_opc_data"}, 128'(bus.opc_data_o), 128'(0));
    endtask

    task automatic send(input logic [TagWidth-1:0] tag, input logic [NumOperands-1:0] mask,
                        input logic [NumOperands*AddrWidth-1:0] addrs, input int stall,
                        input int bp, input bit abort);
        exp_t e;
        int   k = 0;
        int   n;
        int   req_target;
        int   done_target;
        e.tag  = tag;
        e.data = '0;
        for (int i = 0; i < NumOperands; i++) begin
            if (mask[i]) begin
                k++;
                e.data[i*DataWidth +: DataWidth] = 32'(addrs[i*AddrWidth +: AddrWidth]) * 32'h11;
                rdq.push_back(addrs[i*AddrWidth +: AddrWidth]);
            end
        end
        e.lat = (k == 0) ? 1 : k + 2 + stall;
        if (!abort) exp_q.push_back(e);

        n = 0;
        while (!bus.insn_ready_o && n < 50) begin step(); n++; end
        check_eq("insn_ready_wait", 128'(bus.insn_ready_o), 128'(1));

        bus.insn_valid_i    = 1'b1;
        bus.insn_tag_i      = tag;
        bus.insn_op_valid_i = mask;
        bus.insn_op_addr_i  = addrs;
        if (bp > 0) bus.opc_ready_i = 1'b0;
        req_target  = req_cnt + 2;
        done_target = done_cnt + 1;
        step();
        bus.insn_valid_i = 1'b0;

        if (stall > 0) begin
            bus.rf_read_ready_i = 1'b0;
            repeat (stall) step();
            bus.rf_read_ready_i = 1'b1;
        end

        if (abort) begin
            n = 0;
            while (req_cnt < req_target && n < 50) begin step(); n++; end
            check_eq("abort_reqs", 128'(req_cnt), 128'(req_target));
            // The second response is on the bus for the coming edge; reset must swallow it.
            rst_ni = 1'b0;
            #1;
            check_reset_outputs("mid_rst");
            rdq.delete();
            opc_valid_prev = 1'b0;
            opc_hs_prev    = 1'b0;
            repeat (2) step();
            rst_ni = 1'b1;
            step();
            check_reset_outputs("post_rst");
            return;
        end

        if (bp > 0) begin
            n = 0;
            while (!bus.opc_valid_o && n < 50) begin step(); n++; end
            check_eq("bp_valid_seen", 128'(bus.opc_valid_o), 128'(1));
            repeat (bp) step();
            bus.opc_ready_i = 1'b1;
        end

        n = 0;
        while (done_cnt < done_target && n < 100) begin step(); n++; end
        check_eq("bundle_done", 128'(done_cnt), 128'(done_target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.insn_valid_i    = 1'b0;
        bus.insn_tag_i      = '0;
        bus.insn_op_valid_i = '0;
        bus.insn_op_addr_i  = '0;
        bus.rf_read_ready_i = 1'b1;
        bus.opc_ready_i     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        step();

        // addr packing: {slot2, slot1, slot0}
        send(4'd5,  3'b111, {8'd30, 8'd20, 8'd10}, 0, 0, 1'b0);   // full mask
        send(4'd6,  3'b101, {8'd9, 8'd99, 8'd7},   0, 0, 1'b0);   // sparse, slot1 stays 0
        send(4'd3,  3'b000, {8'd1, 8'd2, 8'd3},    0, 0, 1'b0);   // empty mask
        send(4'd9,  3'b111, {8'd3, 8'd2, 8'd1},    4, 0, 1'b0);   // bank stall on first read
        send(4'd10, 3'b011, {8'd0, 8'd201, 8'd200}, 0, 10, 1'b0); // downstream backpressure
        send(4'd11, 3'b111, {8'd5, 8'd5, 8'd5},    0, 0, 1'b0);   // duplicate addresses
        send(4'd2,  3'b111, {8'd70, 8'd60, 8'd50}, 0, 0, 1'b1);   // reset after 2nd read
        send(4'd12, 3'b110, {8'd255, 8'd40, 8'd0}, 0, 0, 1'b0);   // recovers after reset
        for (int t = 0; t < 6; t++) begin
            send(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 24'($urandom), 0, 0, 1'b0);
        end
        step();

        check_eq("exp_q_drained", 128'(exp_q.size()), 128'(0));
        check_eq("rdq_drained", 128'(rdq.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
